// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch_lap block.
// Optional build macro used by the top: STOPWATCH_SATURATE_EN.
package stopwatch_pkg;

  // Run-control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  // One BCD digit
  typedef logic [3:0] bcd_t;

  // Digit moduli: decimal digits and the tens-of-seconds/tens-of-minutes digits
  localparam int unsigned MOD_DEC = 32'd10;
  localparam int unsigned MOD_SIX = 32'd6;

  // Largest representable count, 59:59.99, as packed digits mm:ss.cc
  localparam logic [23:0] MAX_COUNT = 24'h59_5999;

  // True when the packed six-digit count sits at 59:59.99
  function automatic logic is_max_count(input logic [23:0] cnt);
    return (cnt == MAX_COUNT);
  endfunction

endpackage

// File: rtl/bcd_digit_mod.sv
// One BCD digit of the live count with a configurable modulus.
// carry is combinational: it fires when the incoming increment would wrap
// this digit, and it drives the next digit's increment.
module bcd_digit_mod #(
  parameter int unsigned MOD = 32'd10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);
  import stopwatch_pkg::*;

  localparam bcd_t TOP = bcd_t'(MOD - 32'd1);

  bcd_t q_q;
  bcd_t q_d;

  // Next digit value: clear wins, then increment with wrap; any out-of-range
  // value is folded back to zero so the digit stays a legal BCD symbol.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      if (q_q >= TOP) begin
        q_d = 4'd0;
      end else begin
        q_d = q_q + 4'd1;
      end
    end else if (q_q > TOP) begin
      q_d = 4'd0;
    end else begin
      q_d = q_q;
    end
  end

  // Digit register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == TOP);

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch core: mm:ss.cc BCD count advanced by a centisecond tick derived
// from the millisecond enable, with start/stop, lap freeze and clear.
// Build option: define STOPWATCH_SATURATE_EN to hold at 59:59.99 and pause
// on overflow instead of wrapping to 00:00.00.
module stopwatch_lap #(
  parameter int unsigned TICK_DIV = 32'd10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_msec,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic [3:0] cs10,
  output logic [3:0] cs1,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);
  import stopwatch_pkg::*;

  localparam logic [9:0] PRESC_TOP = 10'(TICK_DIV - 32'd1);

  sw_state_t   state_q;
  sw_state_t   state_d;
  logic [9:0]  presc_q;
  logic [9:0]  presc_d;
  logic        lap_q;
  logic        lap_d;
  logic        ovf_q;
  logic        ovf_d;
  logic        run_q;
  logic        run_d;
  logic [23:0] disp_q;
  logic [23:0] disp_d;

  logic        clr_s;
  logic        cs_tick_s;
  logic        inc_s;
  logic        at_max_s;
  logic        ovf_evt_s;
  logic [23:0] live_s;

  bcd_t live_min10_s;
  bcd_t live_min1_s;
  bcd_t live_sec10_s;
  bcd_t live_sec1_s;
  bcd_t live_cs10_s;
  bcd_t live_cs1_s;
  logic c_cs1_s;
  logic c_cs10_s;
  logic c_sec1_s;
  logic c_sec10_s;
  logic c_min1_s;
  logic c_min10_s;

  // A centisecond elapses on the millisecond pulse that completes the prescaler
  assign cs_tick_s = (state_q == RUN) && clk_msec && (presc_q >= PRESC_TOP);

  assign live_s   = {live_min10_s, live_min1_s, live_sec10_s,
                     live_sec1_s, live_cs10_s, live_cs1_s};
  assign at_max_s = is_max_count(live_s);

`ifdef STOPWATCH_SATURATE_EN
  // The count freezes at 59:59.99 instead of rolling over
  assign inc_s = cs_tick_s && !at_max_s;
`else
  assign inc_s = cs_tick_s;
`endif

  // Overflow event: a tick arriving at full scale (top carry covers the wrap)
  assign ovf_evt_s = (cs_tick_s && at_max_s) || c_min10_s;

  // Live count: cascaded digits, each incremented by the previous carry
  bcd_digit_mod #(.MOD(MOD_DEC)) u_cs1 (
    .clk(clk), .reset_p(reset_p), .clr(clr_s), .inc(inc_s),
    .q(live_cs1_s), .carry(c_cs1_s)
  );
  bcd_digit_mod #(.MOD(MOD_DEC)) u_cs10 (
    .clk(clk), .reset_p(reset_p), .clr(clr_s), .inc(c_cs1_s),
    .q(live_cs10_s), .carry(c_cs10_s)
  );
  bcd_digit_mod #(.MOD(MOD_DEC)) u_sec1 (
    .clk(clk), .reset_p(reset_p), .clr(clr_s), .inc(c_cs10_s),
    .q(live_sec1_s), .carry(c_sec1_s)
  );
  bcd_digit_mod #(.MOD(MOD_SIX)) u_sec10 (
    .clk(clk), .reset_p(reset_p), .clr(clr_s), .inc(c_sec1_s),
    .q(live_sec10_s), .carry(c_sec10_s)
  );
  bcd_digit_mod #(.MOD(MOD_DEC)) u_min1 (
    .clk(clk), .reset_p(reset_p), .clr(clr_s), .inc(c_sec10_s),
    .q(live_min1_s), .carry(c_min1_s)
  );
  bcd_digit_mod #(.MOD(MOD_SIX)) u_min10 (
    .clk(clk), .reset_p(reset_p), .clr(clr_s), .inc(c_min1_s),
    .q(live_min10_s), .carry(c_min10_s)
  );

  // Run-control FSM: buttons resolved as clear > start > lap per state
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q | ovf_evt_s;
    clr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        // Clear has nothing to act on here, so start is the effective pulse
        if (btn_start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (btn_start) begin
          state_d = PAUSE;
        end else if (btn_lap) begin
          lap_d = ~lap_q;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (btn_clear) begin
          state_d = IDLE;
          clr_s   = 1'b1;
          lap_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (btn_start) begin
          state_d = RUN;
        end else if (btn_lap) begin
          lap_d = 1'b0;
        end else begin
          state_d = PAUSE;
        end
      end
      default: begin
        state_d = IDLE;
        lap_d   = 1'b0;
        clr_s   = 1'b1;
      end
    endcase
`ifdef STOPWATCH_SATURATE_EN
    if (cs_tick_s && at_max_s) begin
      state_d = PAUSE;
    end else begin
      state_d = state_d;
    end
`endif
    run_d = (state_d == RUN);
  end

  // Prescaler: counts millisecond pulses in RUN, holds otherwise
  always_comb begin
    presc_d = presc_q;
    if (clr_s) begin
      presc_d = 10'd0;
    end else if ((state_q == RUN) && clk_msec) begin
      if (presc_q >= PRESC_TOP) begin
        presc_d = 10'd0;
      end else begin
        presc_d = presc_q + 10'd1;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Display tracks the live count one clock behind unless lap-frozen
  always_comb begin
    disp_d = disp_q;
    if (clr_s) begin
      disp_d = 24'd0;
    end else if (!lap_q) begin
      disp_d = live_s;
    end else begin
      disp_d = disp_q;
    end
  end

  // Control, prescaler, flag and display registers
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      presc_q <= 10'd0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
      disp_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
      run_q   <= run_d;
      disp_q  <= disp_d;
    end
  end

  assign {min10, min1, sec10, sec1, cs10, cs1} = disp_q;
  assign running    = run_q;
  assign lap_active = lap_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap. The reference model keeps the time
// as a plain centisecond total and converts it to digits arithmetically.
module tb_stopwatch_lap;

  localparam int TD   = 10;
  localparam int MAXC = 359999;
  localparam int MI   = 0;
  localparam int MR   = 1;
  localparam int MP   = 2;

  logic clk = 1'b0;
  logic reset_p, clk_msec, btn_start, btn_lap, btn_clear;
  logic [3:0] min10, min1, sec10, sec1, cs10, cs1;
  logic running, lap_active, overflow;

  int errors = 0;
  int checks = 0;

  int m_mode, m_presc, m_live, m_disp;
  bit m_lap, m_ovf;

  always #5 clk = ~clk;

  stopwatch_lap #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset_p(reset_p), .clk_msec(clk_msec),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .cs10(cs10), .cs1(cs1),
    .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  function automatic logic [23:0] to_bcd(input int t);
    int mn, sc, cs;
    mn = t / 6000;
    sc = (t / 100) % 60;
    cs = t % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/disp"}, {8'h0, min10, min1, sec10, sec1, cs10, cs1}, {8'h0, to_bcd(m_disp)});
    chk({tag, "/flags"}, {29'd0, running, lap_active, overflow},
        {29'd0, (m_mode == MR), m_lap, m_ovf});
    chk({tag, "/live"}, {8'h0, dut.u_min10.q, dut.u_min1.q, dut.u_sec10.q,
                         dut.u_sec1.q, dut.u_cs10.q, dut.u_cs1.q},
        {8'h0, to_bcd(m_live)});
  endtask

  task automatic model_reset();
    m_mode = MI; m_presc = 0; m_live = 0; m_disp = 0; m_lap = 0; m_ovf = 0;
  endtask

  // One clock of the stopwatch rules, applied to the pre-edge state
  task automatic model_step(input bit st, input bit lp, input bit cl, input bit ms);
    int old_live;
    bit old_lap, zap, tick;
    old_live = m_live; old_lap = m_lap; zap = 0; tick = 0;
    case (m_mode)
      MI: if (st) m_mode = MR;
      MR: begin
        if (ms) begin
          if (m_presc == TD - 1) begin m_presc = 0; tick = 1; end
          else m_presc++;
        end
        if (st) m_mode = MP;
        else if (lp) m_lap = !m_lap;
        if (tick) begin
          if (m_live == MAXC) begin
            m_ovf = 1;
`ifdef STOPWATCH_SATURATE_EN
            m_mode = MP;
`else
            m_live = 0;
`endif
          end else begin
            m_live++;
          end
        end
      end
      default: begin
        if (cl) begin
          m_mode = MI; m_live = 0; m_presc = 0; m_lap = 0; m_ovf = 0; zap = 1;
        end else if (st) m_mode = MR;
        else if (lp) m_lap = 0;
      end
    endcase
    if (zap) m_disp = 0;
    else if (!old_lap) m_disp = old_live;
  endtask

  // Called at a falling edge: drive, take the rising edge, check at next fall
  task automatic cyc(input bit st, input bit lp, input bit cl, input bit ms);
    btn_start = st; btn_lap = lp; btn_clear = cl; clk_msec = ms;
    @(posedge clk);
    model_step(st, lp, cl, ms);
    #1;
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; clk_msec = 1'b0;
    @(negedge clk);
    check_all("cyc");
  endtask

  // Run with random millisecond density until the model reaches a target
  task automatic run_to(input int target, input string tag);
    int n;
    n = 0;
    while (m_live != target && n < 60000) begin
      cyc(1'b0, 1'b0, 1'b0, ($urandom_range(0, 3) != 0));
      n++;
    end
    chk({tag, "/reached"}, {8'h0, dut.u_min10.q, dut.u_min1.q, dut.u_sec10.q,
                            dut.u_sec1.q, dut.u_cs10.q, dut.u_cs1.q},
        {8'h0, to_bcd(target)});
  endtask

  function automatic logic [31:0] disp_word();
    return {8'h0, min10, min1, sec10, sec1, cs10, cs1};
  endfunction

  initial begin
    reset_p = 1'b1; clk_msec = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset_disp", disp_word(), 32'h0);
    reset_p = 1'b0;

    // Start, ten millisecond pulses make one centisecond
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_cs", disp_word(), 32'h000001);
    chk("first_run", {31'd0, running}, 32'd1);
    for (int i = 0; i < 990; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("one_sec", disp_word(), 32'h000100);

    // Carry chain 00:09.99 -> 00:10.00, display one clock later
    run_to(999, "to_999");
    for (int i = 0; i < TD - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("carry_live", {8'h0, dut.u_min10.q, dut.u_min1.q, dut.u_sec10.q,
                       dut.u_sec1.q, dut.u_cs10.q, dut.u_cs1.q}, 32'h001000);
    chk("carry_disp_old", disp_word(), 32'h000999);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("carry_disp_new", disp_word(), 32'h001000);

    // Pause, clear, then lap freeze at 00:03.47
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_disp", disp_word(), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_to(347, "to_347");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_set", {31'd0, lap_active}, 32'd1);
    chk("lap_frozen", disp_word(), 32'h000347);
    run_to(500, "to_500");
    chk("lap_hold", disp_word(), 32'h000347);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_clr", {31'd0, lap_active}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lap_resume", disp_word(), 32'h000500);

    // start+lap in RUN pauses with lap unchanged; clear+start in PAUSE goes idle
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sl_run", {31'd0, running}, 32'd0);
    chk("sl_lap", {31'd0, lap_active}, 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("cs_disp", disp_word(), 32'h0);
    chk("cs_flags", {29'd0, running, lap_active, overflow}, 32'd0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("idle_hold", disp_word(), 32'h0);

    // Preload 59:59.99 while paused, then one more centisecond
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    force dut.u_min10.q_q = 4'd5;
    force dut.u_min1.q_q  = 4'd9;
    force dut.u_sec10.q_q = 4'd5;
    force dut.u_sec1.q_q  = 4'd9;
    force dut.u_cs10.q_q  = 4'd9;
    force dut.u_cs1.q_q   = 4'd9;
    m_live = MAXC;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    release dut.u_min10.q_q;
    release dut.u_min1.q_q;
    release dut.u_sec10.q_q;
    release dut.u_sec1.q_q;
    release dut.u_cs10.q_q;
    release dut.u_cs1.q_q;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("max_disp", disp_word(), 32'h595999);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TD; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef STOPWATCH_SATURATE_EN
    chk("ovf_disp", disp_word(), 32'h595999);
    chk("ovf_run", {31'd0, running}, 32'd0);
`else
    chk("ovf_disp", disp_word(), 32'h000000);
    chk("ovf_run", {31'd0, running}, 32'd1);
`endif

    // Asynchronous reset mid-run at 00:12.34
    if (m_mode == MR) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_to(1234, "to_1234");
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    #2 reset_p = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_disp", disp_word(), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_p = 1'b0;
    check_all("rst_hold");

    // Pause at prescaler 7, resume: tick after three more pulses
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("presc_no_tick", {28'd0, dut.u_cs1.q}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("presc_tick", {28'd0, dut.u_cs1.q}, 32'd1);

    // Random button and millisecond traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
- Stopwatch core fed by the one-cycle millisecond enable pulse from the clock-divider stage; all logic runs on the system clock.
- Keeps a BCD count in mm:ss.cc form, from 00:00.00 to 59:59.99.
- Start/stop, lap-freeze and clear are driven by debounced one-cycle button pulses.
- Feeds the 7-segment scan/display stage with six BCD digits plus status flags.

Parameters:
- TICK_DIV, 10, number of clk_msec pulses per centisecond (range 2..1023).

Ports:
- clk  in  1  system clock (100 MHz)
- reset_p  in  1  asynchronous, active-high reset
- clk_msec  in  1  one-clk-wide enable pulse, once per millisecond
- btn_start  in  1  one-cycle pulse; toggles run/pause
- btn_lap  in  1  one-cycle pulse; toggles display freeze
- btn_clear  in  1  one-cycle pulse; zeroes count
- min10, min1, sec10, sec1, cs10, cs1  out  4 each  displayed BCD digits
- running  out  1  high in RUN
- lap_active  out  1  high while the display is frozen
- overflow  out  1  sticky; set on wrap or saturation

Behaviour:
- Reset is asynchronous and active-high. It forces: state=IDLE, prescaler=0, live count=0, all display digits=0, running=0, lap_active=0, overflow=0.

FSM states: IDLE, RUN, PAUSE.
- IDLE: btn_start -> RUN. btn_lap is ignored. btn_clear has no effect beyond keeping everything at zero.
- RUN: btn_start -> PAUSE. btn_clear is ignored. btn_lap toggles lap_active.
- PAUSE: btn_start -> RUN. btn_clear -> IDLE, zeroing the live count, prescaler, display, lap_active and overflow. btn_lap clears lap_active if set; otherwise no effect.

Simultaneous pulses:
- Priority is clear > start > lap. Only the highest-priority effective pulse acts in a given cycle.
- Example: clear+start in PAUSE -> IDLE only.
- Example: start+lap in RUN -> PAUSE; the lap pulse is dropped.

Prescaler:
- Counts clk_msec pulses only in RUN, from 0 to TICK_DIV-1.
- The pulse that arrives at TICK_DIV-1 sets prescaler to 0 and produces a one-cycle cs_tick in the same clk.
- The prescaler holds its value in PAUSE, so a resumed run continues mid-centisecond. It is zeroed on clear.

Live count:
- Cascaded BCD digits with moduli cs1/10, cs10/10, sec1/10, sec10/6, min1/10, min10/6.
- A digit's carry-out fires when the incoming carry is high and the digit is at max-1. That digit wraps to 0 and the next digit increments.
- Digits never hold non-BCD values.
- A cs_tick at 59:59.99 wraps the count to 00:00.00 and sets overflow. The state stays RUN.

Display:
- Display registers copy the live count every clk while lap_active=0. Latency is 1 clk from a live-count change.
- The btn_lap pulse that sets lap_active also copies the live count that same cycle, so the frozen value equals the live count at the press.
- While frozen, the live count keeps running.
- When lap_active clears, the display resumes tracking on the next clk.

Reset mid-run: returns to IDLE immediately, with no pending tick retained.

Optional Feature:
- Macro STOPWATCH_SATURATE_EN.
- Defined: a cs_tick at 59:59.99 leaves the count at 59:59.99, sets overflow, and the FSM moves to PAUSE, so running=0 on the next clk.
- Undefined: the count wraps to 00:00.00 with overflow set, as above.

Decomposition:
- Shared package stopwatch_pkg holds:
  - sw_state_t enum (IDLE, RUN, PAUSE)
  - bcd_t (4-bit) typedef
  - constants for digit moduli (10, 6) and the max count 59:59.99
- One natural sub-module, bcd_digit_mod, instantiated 6 times:
  - parameter MOD
  - inputs: clk, reset_p, clr, inc
  - outputs: q[3:0], carry
  - carry is combinational (inc && q==MOD-1).

Test Plan:
- Reset, then btn_start, then 10 clk_msec pulses (TICK_DIV=10) -> cs1=1, running=1. After 1000 pulses -> sec1=1, cs=00.
- Run to 00:09.99, then one more centisecond -> display 00:10.00. Check the carry chain on the same clk, with the display 1 clk later.
- Lap at 00:03.47 -> display frozen at 00:03.47 and lap_active=1 while live continues. Second lap at live 00:05.00 -> display shows 00:05.00 on the next clk.
- In RUN, pulse btn_start+btn_lap together -> PAUSE, lap_active unchanged. Then btn_clear+btn_start together -> IDLE with all digits 0.
- Preload the count via a run to 59:59.99, then one centisecond:
  - Without the macro -> 00:00.00, overflow=1, running=1.
  - With STOPWATCH_SATURATE_EN -> 59:59.99, overflow=1, running=0.
- Assert reset_p asynchronously (between clk edges) in RUN at 00:12.34 -> outputs zero immediately. Pause at prescaler=7 then resume -> the first cs_tick arrives after 3 clk_msec pulses.
